// File: rtl/pattern_detector_pkg.sv
// Shared types and defaults for the serial pattern detector.
package pattern_detector_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    localparam int DEFAULT_MAX_LEN = 8;
    localparam int DEFAULT_CNT_W   = 16;

    // Width needed to hold a pattern length from 0 up to max_len inclusive.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pattern_detector.sv
// Serial bit-pattern detector with runtime-loadable pattern/length and
// optional overlapping matches; counts matches in a saturating counter.
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           seq_valid,
    input  logic                           seq,
    input  logic                           cfg_load,
    input  logic [MAX_LEN-1:0]             pattern,
    input  logic [len_width(MAX_LEN)-1:0]  pattern_len,
    input  logic                           overlap_en,
    input  logic                           clear,
    output logic                           set,
    output logic [CNT_W-1:0]               match_count,
    output logic                           armed,
    output logic                           cfg_err
);

    localparam int LEN_W = len_width(MAX_LEN);

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               set_q, set_d;

    logic               cur_legal;
    logic               new_legal;
    logic               accept;
    logic               match;
    logic [MAX_LEN-1:0] shift_hist;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] len_mask;

    assign cur_legal = (len_q >= LEN_W'(2)) && (len_q <= LEN_W'(MAX_LEN));
    assign new_legal = (pattern_len >= LEN_W'(2)) && (pattern_len <= LEN_W'(MAX_LEN));

    // Only the low len_q history bits take part in the comparison.
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
        assign len_mask[gi] = (LEN_W'(gi) < len_q);
    end

    assign shift_hist = {hist_q[MAX_LEN-2:0], seq};
    assign fill_inc   = (fill_q >= len_q) ? len_q : (fill_q + LEN_W'(1));
    assign accept     = seq_valid && !clear && !cfg_load && (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        match   = 1'b0;

        if (cfg_load) begin
            pat_d   = pattern;
            len_d   = pattern_len;
            ovl_d   = overlap_en;
            hist_d  = '0;
            fill_d  = '0;
            state_d = new_legal ? FILL : IDLE;
        end else if (clear) begin
            hist_d = '0;
            fill_d = '0;
            if (state_q == ARMED) begin
                state_d = FILL;
            end
        end else if (accept) begin
            hist_d = shift_hist;
            fill_d = fill_inc;
            if (fill_inc == len_q) begin
                match = (((shift_hist ^ pat_q) & len_mask) == '0);
                // Without overlap the window restarts, so the next match needs len_q fresh bits.
                if (match && !ovl_q) begin
                    fill_d  = '0;
                    state_d = FILL;
                end else begin
                    state_d = ARMED;
                end
            end
        end

        set_d = match;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            set_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            set_q   <= set_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (match),
        .count (match_count)
    );

    assign set     = set_q;
    assign armed   = (state_q == ARMED);
    assign cfg_err = !cur_legal;

endmodule
